// File: rtl/noc_pkt_rx.sv
// Local-port NoC receiver: reassembles per-VC flit streams into a single
// beat stream with sop/eop, head fields and beat index; flags protocol errors.
module noc_pkt_rx #(
  parameter int N_VIRT_CHN = 3,
  parameter int VC_ID_W    = 2,
  parameter int FLIT_WIDTH = 34,
  parameter int PKT_SIZE_W = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [FLIT_WIDTH-1:0] flit_data_i,
  input  logic                  valid_i,
  input  logic [VC_ID_W-1:0]    vc_id_i,
  output logic                  ready_o,
  output logic                  pkt_valid_o,
  input  logic                  pkt_ready_i,
  output logic [31:0]           pkt_data_o,
  output logic                  pkt_sop_o,
  output logic                  pkt_eop_o,
  output logic [VC_ID_W-1:0]    pkt_vc_o,
  output logic [1:0]            pkt_x_o,
  output logic [1:0]            pkt_y_o,
  output logic [PKT_SIZE_W-1:0] pkt_size_o,
  output logic [PKT_SIZE_W-1:0] pkt_idx_o,
  output logic                  err_o,
  output logic [VC_ID_W-1:0]    err_vc_o,
  output logic [N_VIRT_CHN-1:0] err_sticky_o,
  input  logic [N_VIRT_CHN-1:0] err_clr_i
);

  typedef enum logic {VC_IDLE, VC_IN_PKT} vc_state_e;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  vc_state_e             state_q [N_VIRT_CHN];
  vc_state_e             state_d [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] rem_q   [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] rem_d   [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] size_q  [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] size_d  [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] idx_q   [N_VIRT_CHN];
  logic [PKT_SIZE_W-1:0] idx_d   [N_VIRT_CHN];
  logic [1:0]            x_q     [N_VIRT_CHN];
  logic [1:0]            x_d     [N_VIRT_CHN];
  logic [1:0]            y_q     [N_VIRT_CHN];
  logic [1:0]            y_d     [N_VIRT_CHN];

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [VC_ID_W-1:0]    out_vc_q, out_vc_d;
  logic [1:0]            out_x_q, out_x_d;
  logic [1:0]            out_y_q, out_y_d;
  logic [PKT_SIZE_W-1:0] out_size_q, out_size_d;
  logic [PKT_SIZE_W-1:0] out_idx_q, out_idx_d;
  logic                  err_q, err_d;
  logic [VC_ID_W-1:0]    err_vc_q, err_vc_d;
  logic [N_VIRT_CHN-1:0] sticky_q, sticky_d;

  logic                  accept;
  logic [1:0]            ftype;
  logic [31:0]           fdata;
  logic                  vc_ok;
  vc_state_e             sel_state, nxt_state;
  logic [PKT_SIZE_W-1:0] sel_rem, sel_size, sel_idx, nxt_rem, nxt_idx;
  logic [1:0]            sel_x, sel_y;
  logic                  emit, flit_err, capture;
  logic [31:0]           b_data;
  logic                  b_sop, b_eop;
  logic [1:0]            b_x, b_y;
  logic [PKT_SIZE_W-1:0] b_size, b_idx;

  assign ready_o = ~arst & (~out_valid_q | pkt_ready_i);
  assign accept  = valid_i & ready_o;
  assign ftype   = flit_data_i[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign fdata   = flit_data_i[31:0];

  always_comb begin
    vc_ok     = 1'b0;
    sel_state = VC_IDLE;
    sel_rem   = '0;
    sel_size  = '0;
    sel_idx   = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (int'(vc_id_i) == v) begin
        vc_ok     = 1'b1;
        sel_state = state_q[v];
        sel_rem   = rem_q[v];
        sel_size  = size_q[v];
        sel_idx   = idx_q[v];
        sel_x     = x_q[v];
        sel_y     = y_q[v];
      end
    end
  end

  // Classify the incoming flit against its VC's reassembly state.
  always_comb begin
    emit      = 1'b0;
    flit_err  = 1'b0;
    capture   = 1'b0;
    nxt_state = sel_state;
    nxt_rem   = sel_rem;
    nxt_idx   = sel_idx;
    b_data    = fdata;
    b_sop     = 1'b0;
    b_eop     = 1'b0;
    b_x       = sel_x;
    b_y       = sel_y;
    b_size    = sel_size;
    b_idx     = sel_idx;
    if (!vc_ok) begin
      flit_err = 1'b1;
    end else begin
      case (ftype)
        T_HEAD: begin
          if (sel_state == VC_IDLE) begin
            emit   = 1'b1;
            b_data = {12'h0, fdata[19:0]};
            b_sop  = 1'b1;
            b_x    = fdata[31:30];
            b_y    = fdata[29:28];
            b_size = fdata[27:20];
            b_idx  = '0;
            if (fdata[27:20] == '0) begin
              b_eop = 1'b1;
            end else begin
              capture   = 1'b1;
              nxt_state = VC_IN_PKT;
              nxt_rem   = fdata[27:20];
              nxt_idx   = PKT_SIZE_W'(1);
            end
          end else begin
            flit_err = 1'b1;
          end
        end
        T_BODY: begin
          if (sel_state == VC_IN_PKT && sel_rem > PKT_SIZE_W'(1)) begin
            emit    = 1'b1;
            nxt_rem = sel_rem - PKT_SIZE_W'(1);
            nxt_idx = sel_idx + PKT_SIZE_W'(1);
          end else begin
            flit_err = 1'b1;
          end
        end
        T_TAIL: begin
          if (sel_state == VC_IN_PKT && sel_rem == PKT_SIZE_W'(1)) begin
            emit      = 1'b1;
            b_eop     = 1'b1;
            nxt_state = VC_IDLE;
          end else begin
            flit_err = 1'b1;
          end
        end
        default: flit_err = 1'b1;
      endcase
      if (flit_err) nxt_state = VC_IDLE;
    end
  end

  // Per-VC write-back, error reporting and the single output register.
  always_comb begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      state_d[v] = state_q[v];
      rem_d[v]   = rem_q[v];
      size_d[v]  = size_q[v];
      idx_d[v]   = idx_q[v];
      x_d[v]     = x_q[v];
      y_d[v]     = y_q[v];
    end
    sticky_d = sticky_q & ~err_clr_i;
    err_d    = 1'b0;
    err_vc_d = '0;
    if (accept && vc_ok) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        if (int'(vc_id_i) == v) begin
          state_d[v] = nxt_state;
          rem_d[v]   = nxt_rem;
          idx_d[v]   = nxt_idx;
          if (capture) begin
            size_d[v] = fdata[27:20];
            x_d[v]    = fdata[31:30];
            y_d[v]    = fdata[29:28];
          end
          if (flit_err) sticky_d[v] = 1'b1;
        end
      end
    end
    if (accept && flit_err) begin
      err_d    = 1'b1;
      err_vc_d = vc_ok ? vc_id_i : VC_ID_W'(N_VIRT_CHN - 1);
    end

    out_valid_d = out_valid_q & ~pkt_ready_i;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_vc_d    = out_vc_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_size_d  = out_size_q;
    out_idx_d   = out_idx_q;
    if (accept && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
      out_sop_d   = b_sop;
      out_eop_d   = b_eop;
      out_vc_d    = vc_id_i;
      out_x_d     = b_x;
      out_y_d     = b_y;
      out_size_d  = b_size;
      out_idx_d   = b_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        state_q[v] <= VC_IDLE;
        rem_q[v]   <= '0;
        size_q[v]  <= '0;
        idx_q[v]   <= '0;
        x_q[v]     <= '0;
        y_q[v]     <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_vc_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_size_q  <= '0;
      out_idx_q   <= '0;
      err_q       <= 1'b0;
      err_vc_q    <= '0;
      sticky_q    <= '0;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        state_q[v] <= state_d[v];
        rem_q[v]   <= rem_d[v];
        size_q[v]  <= size_d[v];
        idx_q[v]   <= idx_d[v];
        x_q[v]     <= x_d[v];
        y_q[v]     <= y_d[v];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_vc_q    <= out_vc_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_size_q  <= out_size_d;
      out_idx_q   <= out_idx_d;
      err_q       <= err_d;
      err_vc_q    <= err_vc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign pkt_valid_o  = out_valid_q;
  assign pkt_data_o   = out_data_q;
  assign pkt_sop_o    = out_sop_q;
  assign pkt_eop_o    = out_eop_q;
  assign pkt_vc_o     = out_vc_q;
  assign pkt_x_o      = out_x_q;
  assign pkt_y_o      = out_y_q;
  assign pkt_size_o   = out_size_q;
  assign pkt_idx_o    = out_idx_q;
  assign err_o        = err_q;
  assign err_vc_o     = err_vc_q;
  assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_noc_pkt_rx.sv
// Scoreboard bench for noc_pkt_rx: directed flits push hand-computed beats and
// error VCs into queues; negedge monitors pop and compare on every handshake.
module tb_noc_pkt_rx;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_BAD  = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  vc;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [7:0]  size;
    logic [7:0]  idx;
  } beat_t;

  logic        clk;
  logic        arst;
  logic [33:0] flit_data_i;
  logic        valid_i;
  logic [1:0]  vc_id_i;
  logic        ready_o;
  logic        pkt_valid_o;
  logic        pkt_ready_i;
  logic [31:0] pkt_data_o;
  logic        pkt_sop_o;
  logic        pkt_eop_o;
  logic [1:0]  pkt_vc_o;
  logic [1:0]  pkt_x_o;
  logic [1:0]  pkt_y_o;
  logic [7:0]  pkt_size_o;
  logic [7:0]  pkt_idx_o;
  logic        err_o;
  logic [1:0]  err_vc_o;
  logic [2:0]  err_sticky_o;
  logic [2:0]  err_clr_i;

  beat_t      exp_q[$];
  logic [1:0] err_exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  noc_pkt_rx #(
    .N_VIRT_CHN(3), .VC_ID_W(2), .FLIT_WIDTH(34), .PKT_SIZE_W(8)
  ) dut (
    .clk(clk), .arst(arst), .flit_data_i(flit_data_i), .valid_i(valid_i),
    .vc_id_i(vc_id_i), .ready_o(ready_o), .pkt_valid_o(pkt_valid_o),
    .pkt_ready_i(pkt_ready_i), .pkt_data_o(pkt_data_o), .pkt_sop_o(pkt_sop_o),
    .pkt_eop_o(pkt_eop_o), .pkt_vc_o(pkt_vc_o), .pkt_x_o(pkt_x_o),
    .pkt_y_o(pkt_y_o), .pkt_size_o(pkt_size_o), .pkt_idx_o(pkt_idx_o),
    .err_o(err_o), .err_vc_o(err_vc_o), .err_sticky_o(err_sticky_o),
    .err_clr_i(err_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Beat monitor: every downstream handshake consumes the oldest expected beat.
  always @(negedge clk) begin
    beat_t act, exp;
    if (pkt_valid_o && pkt_ready_i) begin
      act = '{pkt_data_o, pkt_sop_o, pkt_eop_o, pkt_vc_o, pkt_x_o, pkt_y_o,
              pkt_size_o, pkt_idx_o};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL beat: unexpected beat data=%h vc=%0d idx=%0d, none required",
                 act.data, act.vc, act.idx);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("[TB] FAIL beat: got data=%h sop=%b eop=%b vc=%0d x=%0d y=%0d size=%0d idx=%0d, want data=%h sop=%b eop=%b vc=%0d x=%0d y=%0d size=%0d idx=%0d",
                   act.data, act.sop, act.eop, act.vc, act.x, act.y, act.size, act.idx,
                   exp.data, exp.sop, exp.eop, exp.vc, exp.x, exp.y, exp.size, exp.idx);
        end
      end
    end
  end

  // Error monitor: each err_o pulse consumes the oldest expected error VC.
  always @(negedge clk) begin
    logic [1:0] ev;
    if (err_o) begin
      n_cmp++;
      if (err_exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL err: unexpected error pulse vc=%0d, none required", err_vc_o);
      end else begin
        ev = err_exp_q.pop_front();
        if (err_vc_o !== ev) begin
          n_fail++;
          $display("[TB] FAIL err_vc: got %0d, want %0d", err_vc_o, ev);
        end
      end
    end
  end

  function automatic logic [31:0] mkHead(input logic [1:0] x, input logic [1:0] y,
                                         input logic [7:0] size, input logic [19:0] pl);
    return {x, y, size, pl};
  endfunction

  task automatic expectBeat(input logic [31:0] data, input logic sop, input logic eop,
                            input logic [1:0] vc, input logic [1:0] x, input logic [1:0] y,
                            input logic [7:0] size, input logic [7:0] idx);
    beat_t b;
    b = '{data, sop, eop, vc, x, y, size, idx};
    exp_q.push_back(b);
  endtask

  task automatic expectErr(input logic [1:0] vc);
    err_exp_q.push_back(vc);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Present one flit and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [1:0] ftype, input logic [1:0] vc,
                               input logic [31:0] data);
    logic acc, got;
    flit_data_i = {ftype, data};
    vc_id_i     = vc;
    valid_i     = 1'b1;
    got         = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      if (acc) got = 1'b1;
    end
    #1;
    valid_i = 1'b0;
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL accept: flit type=%b vc=%0d not accepted, want accepted", ftype, vc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    arst        = 1'b1;
    valid_i     = 1'b0;
    flit_data_i = '0;
    vc_id_i     = '0;
    pkt_ready_i = 1'b1;
    err_clr_i   = '0;

    // Reset state
    @(negedge clk);
    checkOutput("ready_in_reset", 32'(ready_o), 32'd0);
    checkOutput("valid_in_reset", 32'(pkt_valid_o), 32'd0);
    checkOutput("sticky_in_reset", 32'(err_sticky_o), 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(ready_o), 32'd1);
    checkOutput("err_after_reset", 32'(err_o), 32'd0);
    idle(1);

    // Head-only packet
    expectBeat(32'h000ACAFE, 1, 1, 2'd0, 2'd0, 2'd3, 8'd0, 8'd0);
    applyStimulus(T_HEAD, 2'd0, mkHead(2'd0, 2'd3, 8'd0, 20'hACAFE));
    idle(3);

    // Four-flit packet back to back
    expectBeat(32'h00000001, 1, 0, 2'd1, 2'd1, 2'd2, 8'd3, 8'd0);
    expectBeat(32'h11111111, 0, 0, 2'd1, 2'd1, 2'd2, 8'd3, 8'd1);
    expectBeat(32'h22222222, 0, 0, 2'd1, 2'd1, 2'd2, 8'd3, 8'd2);
    expectBeat(32'h33333333, 0, 1, 2'd1, 2'd1, 2'd2, 8'd3, 8'd3);
    applyStimulus(T_HEAD, 2'd1, mkHead(2'd1, 2'd2, 8'd3, 20'h00001));
    applyStimulus(T_BODY, 2'd1, 32'h11111111);
    applyStimulus(T_BODY, 2'd1, 32'h22222222);
    applyStimulus(T_TAIL, 2'd1, 32'h33333333);
    idle(3);

    // Interleaved VCs
    expectBeat(32'h00012345, 1, 0, 2'd0, 2'd2, 2'd1, 8'd2, 8'd0);
    expectBeat(32'h00054321, 1, 0, 2'd2, 2'd3, 2'd0, 8'd1, 8'd0);
    expectBeat(32'hAAAA0001, 0, 0, 2'd0, 2'd2, 2'd1, 8'd2, 8'd1);
    expectBeat(32'hBBBB0002, 0, 1, 2'd2, 2'd3, 2'd0, 8'd1, 8'd1);
    expectBeat(32'hAAAA0003, 0, 1, 2'd0, 2'd2, 2'd1, 8'd2, 8'd2);
    applyStimulus(T_HEAD, 2'd0, mkHead(2'd2, 2'd1, 8'd2, 20'h12345));
    applyStimulus(T_HEAD, 2'd2, mkHead(2'd3, 2'd0, 8'd1, 20'h54321));
    applyStimulus(T_BODY, 2'd0, 32'hAAAA0001);
    applyStimulus(T_TAIL, 2'd2, 32'hBBBB0002);
    applyStimulus(T_TAIL, 2'd0, 32'hAAAA0003);
    idle(3);

    // Downstream stall with a flit waiting upstream
    expectBeat(32'h000BEEF0, 1, 0, 2'd2, 2'd1, 2'd0, 8'd2, 8'd0);
    expectBeat(32'hCCCC0001, 0, 0, 2'd2, 2'd1, 2'd0, 8'd2, 8'd1);
    expectBeat(32'hCCCC0002, 0, 1, 2'd2, 2'd1, 2'd0, 8'd2, 8'd2);
    pkt_ready_i = 1'b0;
    applyStimulus(T_HEAD, 2'd2, mkHead(2'd1, 2'd0, 8'd2, 20'hBEEF0));
    fork
      begin
        applyStimulus(T_BODY, 2'd2, 32'hCCCC0001);
        applyStimulus(T_TAIL, 2'd2, 32'hCCCC0002);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          checkOutput("stall_ready", 32'(ready_o), 32'd0);
          checkOutput("stall_hold_data", pkt_data_o, 32'h000BEEF0);
        end
        @(posedge clk);
        #1 pkt_ready_i = 1'b1;
      end
    join
    idle(3);

    // Protocol errors and sticky flags
    expectErr(2'd2);
    applyStimulus(T_TAIL, 2'd2, 32'hDEAD0001);
    expectBeat(32'h00000077, 1, 0, 2'd1, 2'd0, 2'd0, 8'd2, 8'd0);
    applyStimulus(T_HEAD, 2'd1, mkHead(2'd0, 2'd0, 8'd2, 20'h00077));
    expectErr(2'd1);
    applyStimulus(T_TAIL, 2'd1, 32'hDEAD0002);
    idle(3);
    checkOutput("sticky_after_errors", 32'(err_sticky_o), 32'h6);
    expectBeat(32'h00000088, 1, 1, 2'd1, 2'd3, 2'd3, 8'd0, 8'd0);
    applyStimulus(T_HEAD, 2'd1, mkHead(2'd3, 2'd3, 8'd0, 20'h00088));
    idle(2);
    err_clr_i = 3'b010;
    idle(1);
    err_clr_i = 3'b000;
    checkOutput("sticky_after_clear", 32'(err_sticky_o), 32'h4);
    expectErr(2'd2);
    applyStimulus(T_HEAD, 2'd3, mkHead(2'd0, 2'd0, 8'd0, 20'h00001));
    idle(3);
    checkOutput("sticky_bad_vc", 32'(err_sticky_o), 32'h4);
    expectErr(2'd0);
    applyStimulus(T_BAD, 2'd0, 32'h12345678);
    idle(3);
    checkOutput("sticky_bad_type", 32'(err_sticky_o), 32'h5);

    // Reset in the middle of a packet
    expectBeat(32'h00000010, 1, 0, 2'd0, 2'd2, 2'd2, 8'd4, 8'd0);
    expectBeat(32'hEEEE0001, 0, 0, 2'd0, 2'd2, 2'd2, 8'd4, 8'd1);
    applyStimulus(T_HEAD, 2'd0, mkHead(2'd2, 2'd2, 8'd4, 20'h00010));
    applyStimulus(T_BODY, 2'd0, 32'hEEEE0001);
    arst = 1'b1;
    @(negedge clk);
    checkOutput("ready_mid_reset", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_valid", 32'(pkt_valid_o), 32'd0);
    checkOutput("post_reset_data", pkt_data_o, 32'd0);
    checkOutput("post_reset_idx", 32'(pkt_idx_o), 32'd0);
    checkOutput("post_reset_err", 32'(err_o), 32'd0);
    checkOutput("post_reset_sticky", 32'(err_sticky_o), 32'd0);
    checkOutput("post_reset_ready", 32'(ready_o), 32'd1);
    idle(1);
    expectBeat(32'h00000042, 1, 1, 2'd0, 2'd1, 2'd1, 8'd0, 8'd0);
    applyStimulus(T_HEAD, 2'd0, mkHead(2'd1, 2'd1, 8'd0, 20'h00042));
    idle(5);

    checkOutput("beats_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("errors_drained", 32'(err_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_pkt_rx.md
Name: noc_pkt_rx

Overview:
- Egress-side receiver at the local port of a NoC router. Consumes the flit stream the router delivers: head, body and tail flits, interleaved across virtual channels.
- Reassembles per-VC packets into a single beat stream with sop/eop markers, the captured head fields and a length index.
- Detects protocol violations per VC.
- Counterpart of the flit injection path: it is the sink a local processing element uses to receive packets.

Parameters:
- N_VIRT_CHN, 3, number of virtual channels; each has independent reassembly state.
- VC_ID_W, 2, width of the vc_id field (>= clog2(N_VIRT_CHN)).
- FLIT_WIDTH, 34, flit width: type[33:32], data[31:0].
- PKT_SIZE_W, 8, width of the head pkt_size field.

Ports:
- clk  in  1  system clock.
- arst  in  1  synchronous active-high reset, sampled on posedge clk.
- flit_data_i  in  FLIT_WIDTH  incoming flit.
- valid_i  in  1  flit valid.
- vc_id_i  in  VC_ID_W  VC of the incoming flit.
- ready_o  out  1  flit accepted when valid_i & ready_o at posedge.
- pkt_valid_o  out  1  output beat valid.
- pkt_ready_i  in  1  downstream ready.
- pkt_data_o  out  32  beat payload.
- pkt_sop_o  out  1  first beat of a packet.
- pkt_eop_o  out  1  last beat of a packet.
- pkt_vc_o  out  VC_ID_W  VC of the beat.
- pkt_x_o  out  2  x_dest of the packet's head.
- pkt_y_o  out  2  y_dest of the packet's head.
- pkt_size_o  out  PKT_SIZE_W  pkt_size of the packet's head.
- pkt_idx_o  out  PKT_SIZE_W  beat index within the packet (head = 0).
- err_o  out  1  one-cycle pulse on a protocol error.
- err_vc_o  out  VC_ID_W  VC of the error, valid with err_o.
- err_sticky_o  out  N_VIRT_CHN  per-VC sticky error flags.
- err_clr_i  in  N_VIRT_CHN  clears the matching sticky bits.

Behaviour:
- Flit types: HEAD=2'b00, BODY=2'b01, TAIL=2'b10, 2'b11 illegal.
- Head data layout: x_dest[31:30], y_dest[29:28], pkt_size[27:20], payload[19:0].
- Head beat output: pkt_data_o = {12'h0, payload}. Body and tail beats output data[31:0] unchanged.
- pkt_size = number of flits after the head.
  - 0: head-only packet; beat has sop=eop=1.
  - N>0: N-1 BODY flits then exactly one TAIL flit.
- Per-VC state: IDLE / IN_PKT, plus remaining counter rem[PKT_SIZE_W-1:0] and captured x, y, size and idx.
  - IDLE + HEAD: size 0 -> emit sop&eop, stay IDLE. Otherwise capture fields, rem=size, idx=1, go IN_PKT.
  - IN_PKT + BODY with rem>1: emit beat, rem--, idx++.
  - IN_PKT + TAIL with rem==1: emit beat with eop=1, go IDLE.
  - Error cases: BODY or TAIL in IDLE; HEAD in IN_PKT; TAIL with rem>1; BODY with rem==1; type 2'b11. Each error:
    - flit is accepted and dropped; no beat is emitted;
    - err_o=1 and err_vc_o=vc_id_i on the next cycle;
    - err_sticky_o[vc] set;
    - the VC is forced to IDLE, so the partial packet is abandoned (already-emitted beats stand).
- vc_id_i >= N_VIRT_CHN: treated as an error on VC N_VIRT_CHN-1's err_vc_o value. No state changes; the sticky bit is not set.
- Output stage: one register.
  - ready_o = ~arst & (~pkt_valid_o | pkt_ready_i).
  - Accepted legal flit -> beat valid at the next posedge (latency 1).
  - Output fields are held stable while pkt_valid_o & ~pkt_ready_i.
  - Back-to-back throughput is 1 flit/cycle when pkt_ready_i=1.
- Interleaving: flits of different VCs may alternate every cycle. Each VC's counter is independent. Output order equals acceptance order.
- Sticky flags: set has priority over err_clr_i in the same cycle for the same bit.
- Reset (synchronous):
  - all VC states go IDLE, counters 0, output register invalid;
  - all outputs are 0, except ready_o, which is 0 while arst=1 and 1 on the first cycle after.
  - Reset mid-packet discards the partial packet without raising an error.

Test Plan:
- HEAD vc0, x=0, y=3, size=0, payload 20'hACAFE -> next cycle one beat: data 32'h000ACAFE, sop=eop=1, vc=0, y=3, idx=0, no error.
- HEAD vc1 size=3, BODY 32'h11111111, BODY 32'h22222222, TAIL 32'h33333333, pkt_ready_i=1 -> 4 consecutive beats, idx 0..3, sop only on beat 0, eop only on beat 3, pkt_size_o=3 on all.
- Interleaved: vc0 head(size 2) / vc2 head(size 1) / vc0 body / vc2 tail / vc0 tail -> 5 beats in that order. vc2 gets eop on its 2nd beat, vc0 on its 3rd. No errors.
- pkt_ready_i=0 for 4 cycles during a 3-flit packet -> ready_o=0 after the first beat registers, beat held stable, nothing lost. Release -> remaining beats follow 1/cycle.
- TAIL on idle vc2; then HEAD(size 2) vc1 followed by TAIL vc1 -> two err_o pulses (err_vc_o=2, then 1); err_sticky_o=3'b110. Offending flits produce no beat. Subsequent vc1 HEAD(size 0) is delivered normally. err_clr_i=3'b010 -> sticky 3'b100.
- arst asserted for one cycle after HEAD(size 4) + 1 body on vc0 -> outputs 0, no error. New HEAD(size 0) on vc0 delivered with idx=0, sop=eop=1.
